seg7_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver: scans `DIGITS` hex digits onto a shared segment bus with one anode line per digit. Beyond plain scanning, it adds:
- per-digit decimal points and enables,
- leading-zero blanking,
- PWM brightness control,
- anti-ghosting anode gaps,
- tear-free frame-synchronous updates from a load strobe.

It sits between the clock/counter datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_scan_mux_hex_decode.sv | 11 +
 rtl/seg7_scan_mux.sv | 129 ++++++++++++
 tb/tb_seg7_scan_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment-off level,
// active-low hex glyph table and its lookup helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Index = nibble value; bit6..0 = g..a, 0 = segment lit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_mux_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment driver with frame-synchronous shadow loading,
// leading-zero blanking, PWM brightness and an anti-ghost anode gap.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DIV_BITS    = 16,
  parameter int BRIGHT_BITS = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [4*DIGITS-1:0]    x,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic [DIGITS-1:0]      digit_en,
  input  logic                   blank_lz,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic                   load,
  output logic [6:0]             a_to_g,
  output logic                   dp,
  output logic [DIGITS-1:0]      an,
  output logic                   frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic INV = ~ACTIVE_LOW;

  typedef struct packed {
    logic [4*DIGITS-1:0] x;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
    logic                blz;
  } frame_t;

  logic [DIV_BITS-1:0]    pre;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic                   boundary;
  frame_t                 inp;
  frame_t                 pend;
  frame_t                 act;
  logic                   pend_valid;
  logic [DIGITS-1:0]      blank;
  logic                   zero_above;
  logic [BRIGHT_BITS-1:0] sp;
  logic [3:0]             nib;
  logic [6:0]             seg_code;
  logic                   lit;
  logic [6:0]             seg_n;
  logic                   dp_n;
  logic [DIGITS-1:0]      an_n;

  assign inp      = {x, dp_in, digit_en, blank_lz};
  assign tick     = &pre;
  assign boundary = tick && (idx == LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // load is a single-cycle strobe with no backpressure: it is always accepted,
  // the newest capture wins, and active data only changes on the frame boundary.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend       <= '0;
      act        <= '0;
      pend_valid <= 1'b0;
    end else if (boundary) begin
      if (load)            act <= inp;
      else if (pend_valid) act <= pend;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend       <= inp;
      pend_valid <= 1'b1;
    end
  end

  // Walk from the leftmost digit down; a digit blanks while everything above is zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (act.x[4*i +: 4] == 4'h0);
      blank[i]   = act.blz && zero_above;
    end
  end

  assign sp  = pre[DIV_BITS-1 -: BRIGHT_BITS];
  assign nib = act.x[{idx, 2'b00} +: 4];
  assign lit = act.en[idx] && !blank[idx] && (sp <= brightness) && (pre != '0);

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (seg_code)
  );

  always_comb begin
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    an_n  = '1;
    if (lit) begin
      seg_n = seg_code;
      dp_n  = ~act.dp[idx];
      an_n  = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_to_g     <= SEG_OFF ^ {7{INV}};
      dp         <= 1'b1 ^ INV;
      an         <= '1 ^ {DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      a_to_g     <= seg_n ^ {7{INV}};
      dp         <= dp_n ^ INV;
      an         <= an_n ^ {DIGITS{INV}};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised scoreboard bench for seg7_scan_mux (4 digits, 16-clock slots, 2-bit brightness).
module tb_seg7_scan_mux;

  localparam int DIGITS = 4;
  localparam int W      = 13;  // {frame_done, an[3:0], dp, a_to_g[6:0]}
  localparam logic [W-1:0] IDLE = {1'b0, 4'b1111, 1'b1, 7'b1111111};

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] x = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = '0;
  logic        load = 1'b0;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan_mux #(
    .DIGITS      (4),
    .DIV_BITS    (4),
    .BRIGHT_BITS (2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .x          (x),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .load       (load),
    .a_to_g     (a_to_g),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;  // clocks since reset release = index of the state the DUT is in

  // Latest data handed over by load, and the data frozen for the current frame.
  logic [15:0] lat_x, fr_x;
  logic [3:0]  lat_dp, lat_en, fr_dp, fr_en;
  logic        lat_blz, fr_blz;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got fd/an/dp/seg=%b_%b_%b_%b want=%b_%b_%b_%b", name, cyc,
               got[12], got[11:8], got[7], got[6:0], want[12], want[11:8], want[7], want[6:0]);
    end
  endtask

  // Expected registered output produced by clock state c: each frame is 64 clocks,
  // four 16-clock slots, slot subphase = clock-in-slot / 4, clock 0 of a slot is dark.
  function automatic logic [W-1:0] model_out(input int c);
    int pos, slot, sp;
    logic [3:0] nib;
    logic lit, blanked;
    pos     = c % 16;
    slot    = (c / 16) % 4;
    sp      = pos / 4;
    nib     = 4'((fr_x >> (4 * slot)) & 16'hF);
    blanked = (slot > 0) && fr_blz && ((fr_x >> (4 * slot)) == 16'h0);
    lit     = fr_en[slot] && !blanked && (sp <= int'(brightness)) && (pos != 0);
    model_out[12]   = (c % 64 == 63);
    model_out[11:8] = lit ? ~(4'b0001 << slot) : 4'b1111;
    model_out[7]    = lit ? ~fr_dp[slot] : 1'b1;
    model_out[6:0]  = lit ? GLYPH[nib] : 7'b1111111;
  endfunction

  // Reference model: a frame shows the most recent load issued before the frame began.
  initial begin
    forever begin
      @(posedge clk);
      if (clr) begin
        cyc = 0;
        lat_x = '0; lat_dp = '0; lat_en = '0; lat_blz = 1'b0;
        fr_x  = '0; fr_dp  = '0; fr_en  = '0; fr_blz  = 1'b0;
        exp_q.delete();
      end else begin
        if (cyc % 64 == 0) begin
          fr_x = lat_x; fr_dp = lat_dp; fr_en = lat_en; fr_blz = lat_blz;
        end
        exp_q.push_back(model_out(cyc));
        if (load) begin
          lat_x = x; lat_dp = dp_in; lat_en = digit_en; lat_blz = blank_lz;
        end
        cyc++;
      end
    end
  end

  // Monitor: the display presents a new output every clock.
  initial begin
    logic [W-1:0] got, want;
    forever begin
      @(negedge clk);
      got = {frame_done, an, dp, a_to_g};
      if (clr) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("reset_idle", got, IDLE);
      end else if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("scan", got, want);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] xv, input logic [3:0] dpv,
                         input logic [3:0] env, input logic blz);
    x = xv; dp_in = dpv; digit_en = env; blank_lz = blz;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while ((cyc % 64) != p && n < 200) begin
      step(1);
      n++;
    end
    if ((cyc % 64) != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase got=%0d want=%0d", cyc % 64, p);
    end
  endtask

  // Directed spot check of what the pins show right now (state cyc-1).
  task automatic spot(input string name, input logic [W-1:0] want);
    check(name, {frame_done, an, dp, a_to_g}, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    clr = 1'b0;

    // Basic scanning, full brightness.
    brightness = 2'd3;
    do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
    step(64);
    wait_phase(6);
    spot("digit0_F", {1'b0, 4'b1110, 1'b1, 7'b0001110});
    wait_phase(17);
    spot("gap_dark", {1'b0, 4'b1111, 1'b1, 7'b1111111});
    wait_phase(53);
    spot("digit3_1", {1'b0, 4'b0111, 1'b1, 7'b1111001});
    wait_phase(0);
    spot("frame_done", {1'b1, 4'b0111, 1'b1, 7'b1111001});
    step(70);

    // Leading-zero blanking.
    do_load(16'h0050, 4'h0, 4'hF, 1'b1);
    step(130);
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    step(130);

    // Brightness extremes, applied without waiting for a frame.
    do_load(16'h8421, 4'h0, 4'hF, 1'b0);
    brightness = 2'd0;
    step(130);
    brightness = 2'd2;
    step(130);
    brightness = 2'd3;

    // Two loads in one frame: the later one wins at the boundary.
    wait_phase(10);
    do_load(16'h1111, 4'h0, 4'hF, 1'b0);
    step(10);
    do_load(16'h2222, 4'h0, 4'hF, 1'b0);
    step(130);

    // Load coincident with the boundary tick.
    wait_phase(63);
    do_load(16'h3C7E, 4'h5, 4'hF, 1'b0);
    step(70);

    // Decimal point on a disabled digit never shows.
    do_load(16'h9876, 4'b0100, 4'b1011, 1'b0);
    step(130);

    // Reset mid-frame discards pending data; display stays dark afterwards.
    wait_phase(20);
    do_load(16'h5555, 4'hF, 4'hF, 1'b0);
    step(5);
    clr = 1'b1;
    step(2);
    clr = 1'b0;
    step(140);

    // Randomised loads, brightness changes and gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) brightness = 2'($urandom_range(0, 3));
      do_load($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)),
              4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      step($urandom_range(1, 45));
    end
    step(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
